fma16: RTL and testbench

- IEEE 754 binary16 (half-precision) fused multiply-add unit: result = ±(x·y) ± z with a single final rounding.
- Mode bits select a multiply-only, add-only or full FMA operation.
- Exception flags are also produced.
- Used as the scalar FP arithmetic core of the small FPU datapath. The output is registered, with one cycle of latency.

---
 rtl/fma16.sv | 206 ++++++++++++++++++++
 tb/tb_fma16.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16.sv
// fma16: binary16 fused multiply-add, result = (+/-)(x*y) (+/-) z, rounded once.
// The product and the addend are placed exactly in one 81-bit fixed-point
// accumulator whose LSB weighs 2^-48. That is the smallest binary16 product
// bit (2^-24 * 2^-24). Because the sum is exact, the only rounding step is
// the final one, and guard/sticky come straight from the bits left over
// after normalisation. No double rounding can occur.
// Result and flags are registered, so the latency is one cycle.

module fma16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags
);

    localparam logic [1:0] RND_RZ  = 2'b00;
    localparam logic [1:0] RND_RNE = 2'b01;
    localparam logic [1:0] RND_RM  = 2'b10;
    localparam logic [1:0] RND_RP  = 2'b11;

    // Effective operands: y becomes 1.0 when mul=0, and z becomes +0 when add=0.
    logic [15:0] w_op [3];
    assign w_op[0] = x;
    assign w_op[1] = mul ? y : 16'h3c00;
    assign w_op[2] = add ? z : 16'h0000;

    // Per-operand classification and unpacked significand/exponent.
    logic [10:0] w_sig [3];
    logic [4:0]  w_exp [3];
    logic [2:0]  w_is_nan;
    logic [2:0]  w_is_snan;
    logic [2:0]  w_is_inf;
    logic [2:0]  w_is_zero;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dec
            logic [4:0] w_e;
            logic [9:0] w_f;
            assign w_e = w_op[gi][14:10];
            assign w_f = w_op[gi][9:0];
            assign w_is_nan[gi]  = (w_e == 5'h1f) && (w_f != 10'd0);
            assign w_is_snan[gi] = (w_e == 5'h1f) && (w_f != 10'd0) && !w_f[9];
            assign w_is_inf[gi]  = (w_e == 5'h1f) && (w_f == 10'd0);
            assign w_is_zero[gi] = (w_e == 5'd0) && (w_f == 10'd0);
            // Subnormals have no hidden bit and share the exponent of the
            // smallest normal number.
            assign w_sig[gi] = {(w_e != 5'd0), w_f};
            assign w_exp[gi] = (w_e == 5'd0) ? 5'd1 : w_e;
        end
    endgenerate

    // Signs after the optional negations.
    logic w_prod_sign;
    logic w_add_sign;
    assign w_prod_sign = w_op[0][15] ^ w_op[1][15] ^ negp;
    assign w_add_sign  = w_op[2][15] ^ negz;

    // Special-value decisions. These override the finite datapath.
    logic w_inv_mul;
    logic w_prod_inf;
    logic w_inf_sub;
    logic w_invalid;
    logic w_nan_out;
    assign w_inv_mul  = (w_is_inf[0] && w_is_zero[1]) || (w_is_zero[0] && w_is_inf[1]);
    assign w_prod_inf = (w_is_inf[0] || w_is_inf[1]) && !w_inv_mul
                        && !w_is_nan[0] && !w_is_nan[1];
    assign w_inf_sub  = w_prod_inf && w_is_inf[2] && (w_prod_sign != w_add_sign);
    assign w_invalid  = (|w_is_snan) || w_inv_mul || w_inf_sub;
    assign w_nan_out  = (|w_is_nan) || w_inv_mul || w_inf_sub;

    // Exact 22-bit significand product.
    // Its LSB weighs 2^(ex+ey-50), which is bit (ex+ey-2) of the accumulator.
    logic [21:0] w_prod_sig;
    logic [5:0]  w_prod_shift;
    logic [5:0]  w_add_shift;
    logic [80:0] w_prod_al;
    logic [80:0] w_add_al;
    assign w_prod_sig   = 22'(w_sig[0]) * 22'(w_sig[1]);
    assign w_prod_shift = 6'(w_exp[0]) + 6'(w_exp[1]) - 6'd2;
    // The addend LSB weighs 2^(ez-25), which is bit (ez+23) of the accumulator.
    assign w_add_shift  = 6'(w_exp[2]) + 6'd23;
    assign w_prod_al    = 81'(w_prod_sig) << w_prod_shift;
    assign w_add_al     = 81'(w_sig[2]) << w_add_shift;

    // Signed-magnitude add. On effective subtraction the larger magnitude
    // sets the sign.
    logic        w_same_sign;
    logic        w_prod_ge;
    logic [80:0] w_sum;
    logic        w_res_sign;
    assign w_same_sign = (w_prod_sign == w_add_sign);
    assign w_prod_ge   = (w_prod_al >= w_add_al);
    assign w_sum = w_same_sign ? (w_prod_al + w_add_al)
                 : (w_prod_ge  ? (w_prod_al - w_add_al) : (w_add_al - w_prod_al));
    assign w_res_sign = (w_same_sign || w_prod_ge) ? w_prod_sign : w_add_sign;

    // Leading-zero count of the exact sum. The highest set bit wins.
    logic [6:0] w_lz;
    always_comb begin
        w_lz = 7'd81;
        for (int i = 0; i < 81; i++) begin
            if (w_sum[i]) w_lz = 7'(80 - i);
        end
    end

    // Normalise. A leading one below bit 34 (value < 2^-14) is tiny.
    // Clamping the shift at 46 pins the LSB at 2^-24, which denormalises the
    // result before rounding.
    logic [6:0]  w_norm_shift;
    logic [80:0] w_norm;
    logic [10:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_tiny;
    logic [6:0]  w_exp_pre;
    assign w_tiny       = (w_lz > 7'd46);
    assign w_norm_shift = w_tiny ? 7'd46 : w_lz;
    assign w_norm       = w_sum << w_norm_shift;
    assign w_mant       = w_norm[80:70];
    assign w_guard      = w_norm[69];
    assign w_sticky     = |w_norm[68:0];
    assign w_exp_pre    = 7'd47 - w_norm_shift;

    // Packing (exp-1)<<10 plus the 11-bit significand gives the final
    // encoding directly. A round-up carry then moves the result into the
    // next binade, or from subnormal to normal, on its own.
    logic [16:0] w_base;
    logic        w_inexact;
    logic        w_inc;
    logic [16:0] w_rounded;
    logic        w_ovf;
    assign w_base    = ((17'(w_exp_pre) - 17'd1) << 10) + 17'(w_mant);
    assign w_inexact = w_guard || w_sticky;

    // Round-increment decision for the four rounding modes.
    always_comb begin
        w_inc = 1'b0;
        case (roundmode)
            RND_RZ:  w_inc = 1'b0;
            RND_RNE: w_inc = w_guard && (w_sticky || w_mant[0]);
            RND_RM:  w_inc = w_inexact && w_res_sign;
            RND_RP:  w_inc = w_inexact && !w_res_sign;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_rounded = w_base + 17'(w_inc);
    assign w_ovf     = (w_rounded >= 17'h7c00);

    // Overflow goes to infinity when rounding moves away from zero,
    // and to the largest finite value otherwise.
    logic w_ovf_to_inf;
    assign w_ovf_to_inf = (roundmode == RND_RNE)
                       || ((roundmode == RND_RP) && !w_res_sign)
                       || ((roundmode == RND_RM) && w_res_sign);

    // Final result selection: NaN, infinity, exact zero, overflow, finite.
    logic [15:0] w_result_next;
    logic [3:0]  w_flags_next;
    always_comb begin
        w_result_next = 16'h0000;
        w_flags_next  = 4'b0000;
        if (w_nan_out) begin
            w_result_next = 16'h7e00;
            w_flags_next  = {w_invalid, 3'b000};
        end else if (w_prod_inf) begin
            w_result_next = {w_prod_sign, 15'h7c00};
        end else if (w_is_inf[2]) begin
            w_result_next = {w_add_sign, 15'h7c00};
        end else if (w_sum == 81'd0) begin
            w_result_next = {(w_same_sign ? w_prod_sign : (roundmode == RND_RM)), 15'h0000};
        end else if (w_ovf) begin
            w_result_next = {w_res_sign, (w_ovf_to_inf ? 15'h7c00 : 15'h7bff)};
            w_flags_next  = 4'b0101;
        end else begin
            w_result_next = {w_res_sign, w_rounded[14:0]};
            w_flags_next  = {1'b0, 1'b0, (w_tiny && w_inexact), w_inexact};
        end
    end

    // Output register. It clears asynchronously while reset is low.
    logic [15:0] r_result;
    logic [3:0]  r_flags;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= 16'h0000;
            r_flags  <= 4'b0000;
        end else begin
            r_result <= w_result_next;
            r_flags  <= w_flags_next;
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_fma16.sv
// tb_fma16: table-driven directed vectors, hand-written reset/pipeline
// sequences, and randomized operations checked against an exact
// integer reference model of binary16 fused multiply-add.

module tb_fma16;

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RM  = 2'b10;
    localparam logic [1:0] RP  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x, y, z;
    logic        mul, add, negp, negz;
    logic [1:0]  roundmode;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    fma16 dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .z(z),
        .mul(mul), .add(add), .negp(negp), .negz(negz),
        .roundmode(roundmode), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x, y, z;
        logic        mul, add, negp, negz;
        logic [1:0]  rm;
        logic [15:0] exp_res;
        logic [3:0]  exp_flg;
    } vec_t;

    vec_t vt [26];

    task automatic drive(input vec_t v);
        x = v.x; y = v.y; z = v.z;
        mul = v.mul; add = v.add; negp = v.negp; negz = v.negz;
        roundmode = v.rm;
    endtask

    task automatic check(input string name, input logic [15:0] er, input logic [3:0] ef);
        checks++;
        if (result !== er || flags !== ef) begin
            errors++;
            $display("FAIL %s: x=%h y=%h z=%h got result=%h flags=%b, required result=%h flags=%b",
                     name, x, y, z, result, flags, er, ef);
        end else begin
            $display("ok   %s: x=%h y=%h z=%h result=%h flags=%b", name, x, y, z, result, flags);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [10:0] sig_of(input logic [15:0] h);
        return {(h[14:10] != 5'd0), h[9:0]};
    endfunction

    function automatic int exp_of(input logic [15:0] h);
        return (h[14:10] == 5'd0) ? 1 : int'(h[14:10]);
    endfunction

    function automatic logic is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] == 10'd0);
    endfunction

    function automatic logic is_zero(input logic [15:0] h);
        return h[14:0] == 15'd0;
    endfunction

    // Returns {result, flags}. Finite operands become exact integers in units
    // of 2^-48, are added as signed numbers, and are rounded by division by
    // the quantum of the result's binade.
    function automatic logic [19:0] ref_fma(input logic [15:0] a, input logic [15:0] b_in,
                                            input logic [15:0] c_in, input logic mul_i,
                                            input logic add_i, input logic negp_i,
                                            input logic negz_i, input logic [1:0] rm);
        logic [15:0] b, c;
        logic ps, zs, inv_mul, p_inf, inf_sub, invalid, sign, inexact, up, tiny, to_inf;
        logic [127:0] pm, cm, mag, q, n, rem;
        logic signed [127:0] pv, cv, sum;
        int k, e;
        b = mul_i ? b_in : 16'h3c00;
        c = add_i ? c_in : 16'h0000;
        ps = a[15] ^ b[15] ^ negp_i;
        zs = c[15] ^ negz_i;
        inv_mul = (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b));
        p_inf   = (is_inf(a) || is_inf(b)) && !inv_mul && !is_nan(a) && !is_nan(b);
        inf_sub = p_inf && is_inf(c) && (ps != zs);
        invalid = (is_nan(a) && !a[9]) || (is_nan(b) && !b[9]) || (is_nan(c) && !c[9])
                  || inv_mul || inf_sub;
        if (is_nan(a) || is_nan(b) || is_nan(c) || inv_mul || inf_sub)
            return {16'h7e00, invalid, 3'b000};
        if (p_inf) return {ps, 15'h7c00, 4'b0000};
        if (is_inf(c)) return {zs, 15'h7c00, 4'b0000};
        pm  = (128'(sig_of(a)) * 128'(sig_of(b))) << (exp_of(a) + exp_of(b) - 2);
        cm  = 128'(sig_of(c)) << (exp_of(c) + 23);
        pv  = ps ? -$signed(pm) : $signed(pm);
        cv  = zs ? -$signed(cm) : $signed(cm);
        sum = pv + cv;
        if (sum == 0)
            return {((ps == zs) ? ps : (rm == RM)), 15'h0000, 4'b0000};
        sign = (sum < 0);
        mag  = sign ? 128'(-sum) : 128'(sum);
        k = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) k = i;
        e = k - 48;
        if (e < -14) e = -14;
        q   = 128'd1 << (e + 38);
        n   = mag / q;
        rem = mag % q;
        inexact = (rem != 0);
        case (rm)
            RNE:     up = (rem * 2 > q) || ((rem * 2 == q) && n[0]);
            RM:      up = inexact && sign;
            RP:      up = inexact && !sign;
            default: up = 1'b0;
        endcase
        n = n + 128'(up);
        if (n == 128'd2048) begin
            n = 128'd1024;
            e = e + 1;
        end
        tiny = (mag < (128'd1 << 34));
        if (e > 15) begin
            to_inf = (rm == RNE) || (rm == RP && !sign) || (rm == RM && sign);
            return {sign, (to_inf ? 15'h7c00 : 15'h7bff), 4'b0101};
        end
        if (n >= 128'd1024)
            return {sign, 5'(e + 15), 10'(n - 128'd1024), 2'b00, tiny && inexact, inexact};
        return {sign, 5'd0, 10'(n), 2'b00, tiny && inexact, inexact};
    endfunction

    // Random half with extra weight on specials, zeros, subnormals and mid-range exponents.
    function automatic logic [15:0] rand_half();
        int          c;
        logic        s;
        logic [4:0]  e;
        logic [9:0]  f;
        c = $urandom_range(0, 99);
        s = 1'($urandom);
        f = 10'($urandom);
        if (c < 3) begin
            e = 5'h1f; f = 10'd0;
        end else if (c < 8) begin
            e = 5'h1f;
        end else if (c < 15) begin
            e = 5'd0; f = 10'd0;
        end else if (c < 30) begin
            e = 5'd0;
        end else if (c < 70) begin
            e = 5'($urandom_range(10, 20));
        end else begin
            e = 5'($urandom_range(1, 30));
        end
        return {s, e, f};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [19:0] expv;

        //            x        y        z        mul   add   negp  negz  rm   result   flags
        vt[0]  = '{16'h3c00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h3c00, 4'b0000};
        vt[1]  = '{16'h4000, 16'h4200, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h4700, 4'b0000};
        vt[2]  = '{16'h4000, 16'h4200, 16'h3c00, 1'b1, 1'b1, 1'b1, 1'b0, RNE, 16'hc500, 4'b0000};
        vt[3]  = '{16'h3c00, 16'h1234, 16'h3c00, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h4000, 4'b0000};
        vt[4]  = '{16'h3c00, 16'h3c00, 16'hbc00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h0000, 4'b0000};
        vt[5]  = '{16'h3c00, 16'h3c00, 16'hbc00, 1'b1, 1'b1, 1'b0, 1'b0, RM,  16'h8000, 4'b0000};
        vt[6]  = '{16'h7bff, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7c00, 4'b0101};
        vt[7]  = '{16'h7bff, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RZ,  16'h7bff, 4'b0101};
        vt[8]  = '{16'h7bff, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RM,  16'h7bff, 4'b0101};
        vt[9]  = '{16'h7bff, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h7c00, 4'b0101};
        vt[10] = '{16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h0000, 4'b0011};
        vt[11] = '{16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h0001, 4'b0011};
        vt[12] = '{16'h0200, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h0400, 4'b0000};
        vt[13] = '{16'h0000, 16'h7c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7e00, 4'b1000};
        vt[14] = '{16'h7c00, 16'h3c00, 16'hfc00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7e00, 4'b1000};
        vt[15] = '{16'h7e00, 16'h3c00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7e00, 4'b0000};
        vt[16] = '{16'h7c00, 16'h3c00, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7c00, 4'b0000};
        vt[17] = '{16'h3c00, 16'h3c00, 16'h7d00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7e00, 4'b1000};
        vt[18] = '{16'hfbff, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'hfbff, 4'b0101};
        vt[19] = '{16'hfbff, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RM,  16'hfc00, 4'b0101};
        vt[20] = '{16'h3c00, 16'h3c00, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b1, RNE, 16'h0000, 4'b0000};
        vt[21] = '{16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h3c02, 4'b0001};
        vt[22] = '{16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h3c03, 4'b0001};
        vt[23] = '{16'h7d00, 16'h3c00, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7e00, 4'b1000};
        vt[24] = '{16'h3c00, 16'h7c01, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 16'h3c00, 4'b0000};
        vt[25] = '{16'h8001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RM,  16'h8001, 4'b0011};

        // Reset: the outputs clear asynchronously and stay clear across an edge.
        reset = 1'b1;
        drive(vt[0]);
        #1 reset = 1'b0;
        #1 check("reset_async", 16'h0000, 4'b0000);
        @(posedge clk); #1;
        check("reset_over_edge", 16'h0000, 4'b0000);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("reset_release", 16'h3c00, 4'b0000);

        // Directed table.
        for (int i = 0; i < 26; i++) begin
            drive(vt[i]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vt[i].exp_res, vt[i].exp_flg);
        end

        // Back-to-back issue, a held operand, then an asynchronous clear mid-cycle.
        drive(vt[1]);
        @(posedge clk); #1;
        check("b2b_first", 16'h4700, 4'b0000);
        drive(vt[2]);
        @(posedge clk); #1;
        check("b2b_second", 16'hc500, 4'b0000);
        @(posedge clk); #1;
        check("b2b_hold", 16'hc500, 4'b0000);
        #2 reset = 1'b0;
        #1 check("async_clear_midcycle", 16'h0000, 4'b0000);
        @(negedge clk) reset = 1'b1;
        drive(vt[6]);
        @(posedge clk); #1;
        check("after_clear", 16'h7c00, 4'b0101);

        // Randomized operations against the reference model.
        for (int i = 0; i < 1500; i++) begin
            v.x = rand_half();
            v.y = rand_half();
            v.z = rand_half();
            v.mul = ($urandom_range(0, 3) != 0);
            v.add = ($urandom_range(0, 3) != 0);
            v.negp = 1'($urandom);
            v.negz = 1'($urandom);
            v.rm = 2'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                // Near-total cancellation between x and z.
                v.mul = 1'b0;
                v.add = 1'b1;
                v.z = v.x ^ 16'h8000 ^ 16'($urandom_range(0, 3));
                v.negp = 1'b0;
                v.negz = 1'b0;
            end
            expv = ref_fma(v.x, v.y, v.z, v.mul, v.add, v.negp, v.negz, v.rm);
            drive(v);
            @(posedge clk); #1;
            check($sformatf("rnd%0d", i), expv[19:4], expv[3:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
